// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Trial subtraction is A + ~M + 1; carry-out high means no borrow.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   shift_a;
   logic [WIDTH:0]   trial;
   logic             cout;
   logic [WIDTH:0]   a_nxt;
   logic [WIDTH-1:0] q_nxt;

   assign shift_a = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign {cout, trial} = {1'b0, shift_a}
                        + {1'b0, ~{1'b0, m_q}}
                        + {{(WIDTH + 1){1'b0}}, 1'b1};

   assign a_nxt = cout ? trial : shift_a;
   assign q_nxt = {q_q[WIDTH-2:0], cout};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               m_d   = divisor;
               q_d   = dividend;
               a_d   = '0;
               cnt_d = '0;
               dz_d  = 1'b0;
               if (divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            a_d   = a_nxt;
            q_d   = q_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               quot_d  = q_nxt;
               rem_d   = a_nxt[WIDTH-1:0];
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus a random sweep,
// expected results queued at issue and checked on each done.
module tb_seq_divider;

   logic       clk;
   logic       rst_b;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_zero;

   int total;
   int bad;
   int cyc;
   int done_cnt;
   int done_times[$];
   logic [16:0] sb[$];

   seq_divider #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .quotient (quotient),
      .remainder(remainder),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
      end
   endtask

   // expected tuple: {quotient, remainder, div_zero}
   function automatic logic [16:0] model(input logic [7:0] a,
                                         input logic [7:0] b);
      if (b == 8'd0) return {8'hFF, a, 1'b1};
      return {a / b, a % b, 1'b0};
   endfunction

   always @(negedge clk) begin
      logic [16:0] e;
      if (done) begin
         done_cnt++;
         done_times.push_back(cyc);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done got=1 exp=0 t=%0t", $time);
         end else begin
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e[16:9]));
            chk("remainder", int'(remainder), int'(e[8:1]));
            chk("div_zero", int'(div_zero), int'(e[0]));
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   // Called at a negedge with the DUT idle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b);
      int n;
      sb.push_back(model(a, b));
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      chk("busy_after_start", int'(busy), 1);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, (b == 8'd0) ? 1 : 9);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
   endtask

   initial begin
      int d0;
      int t0;
      logic [7:0] ra;
      logic [7:0] rb;
      total    = 0;
      bad      = 0;
      cyc      = 0;
      done_cnt = 0;
      rst_b    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_div_zero", int'(div_zero), 0);
      rst_b = 1'b1;
      @(negedge clk);

      run_op(8'd100, 8'd7);
      run_op(8'd255, 8'd1);
      run_op(8'd5, 8'd9);
      run_op(8'd255, 8'd255);
      run_op(8'd0, 8'd3);
      run_op(8'd200, 8'd0);
      run_op(8'd10, 8'd3);

      // start pulses during ITER and DONE must be ignored
      d0 = done_cnt;
      sb.push_back(model(8'd100, 8'd7));
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("ignore_done_cycle", int'(done), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ignore_back_idle", int'(busy), 0);
      repeat (12) @(negedge clk);
      chk("ignore_one_done", done_cnt - d0, 1);

      // reset in the middle of an operation
      d0 = done_cnt;
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_div_zero", int'(div_zero), 0);
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      run_op(8'd77, 8'd8);

      // start held high: back-to-back operations
      t0 = done_times.size();
      for (int i = 0; i < 3; i++) sb.push_back(model(8'd255, 8'd16));
      start    = 1'b1;
      dividend = 8'd255;
      divisor  = 8'd16;
      repeat (30) @(negedge clk);
      start = 1'b0;
      chk("held_done_count", done_times.size() - t0, 3);
      if (done_times.size() - t0 == 3) begin
         chk("held_gap1", done_times[t0+1] - done_times[t0], 10);
         chk("held_gap2", done_times[t0+2] - done_times[t0+1], 10);
      end
      wait_idle();
      @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = ($urandom_range(0, 7) == 0) ? 8'd0
                                          : 8'($urandom_range(0, 255));
         run_op(ra, rb);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
